// File: rtl/torneo_resolver.sv
// Resolution side of the tournament predictor: queues issued predictions, checks them
// against resolved outcomes, trains the meta selector and redirects on a mispredict.
module torneo_resolver #(
    parameter int unsigned Depth    = 8,
    parameter int unsigned PcStep   = 4,
    parameter int unsigned RecovCyc = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pred_valid_i,
    output logic        pred_ready_o,
    input  logic [31:0] pc_i,
    input  logic        prediction_gh_i,
    input  logic        prediction_ph_i,
    input  logic        prediction_i,
    input  logic [31:0] nex_pc_i,
    input  logic        res_valid_i,
    input  logic        res_taken_i,
    input  logic [31:0] res_target_i,
    output logic        upd_valid_o,
    output logic [31:0] upd_pc_o,
    output logic        fix_result_o,
    output logic [1:0]  meta_dir_o,
    output logic        mispredict_o,
    output logic [31:0] fix_pc_o,
    output logic [15:0] miss_cnt_o,
    output logic        overflow_o,
    output logic        underflow_o
);

    localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned Cw = (RecovCyc > 1) ? $clog2(RecovCyc) : 1;
    localparam logic [Aw:0]   PtrOne   = (Aw + 1)'(1);
    localparam logic [Cw-1:0] RecovTop = Cw'(RecovCyc - 1);
    localparam logic [31:0]   Step     = 32'(PcStep);

    typedef enum logic [0:0] {
        StRun,
        StRecover
    } state_e;

    state_e state_q, state_d;
    logic [Cw-1:0] recov_q, recov_d;
    logic [Aw:0] wr_ptr_q, wr_ptr_d;
    logic [Aw:0] rd_ptr_q, rd_ptr_d;

    logic [31:0] pc_mem_q   [Depth];
    logic [31:0] nex_mem_q  [Depth];
    logic        gh_mem_q   [Depth];
    logic        ph_mem_q   [Depth];
    logic        pred_mem_q [Depth];

    logic        upd_valid_q, fix_result_q, mispredict_q, overflow_q, underflow_q;
    logic [31:0] upd_pc_q, fix_pc_q;
    logic [1:0]  meta_dir_q;
    logic [15:0] miss_cnt_q;

    logic        full, empty, push, pop, push_keep, miss;
    logic [31:0] head_pc, head_nex, correct_pc;
    logic        head_gh, head_ph;
    logic [1:0]  meta_dir;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);

    assign pred_ready_o = (state_q == StRun) && !full;
    assign push         = pred_valid_i && pred_ready_o;
    assign pop          = res_valid_i && !empty && (state_q == StRun);

    assign head_pc  = pc_mem_q[rd_ptr_q[Aw-1:0]];
    assign head_nex = nex_mem_q[rd_ptr_q[Aw-1:0]];
    assign head_gh  = gh_mem_q[rd_ptr_q[Aw-1:0]];
    assign head_ph  = ph_mem_q[rd_ptr_q[Aw-1:0]];

    assign correct_pc = res_taken_i ? res_target_i : (head_pc + Step);
    assign miss       = pop && (head_nex != correct_pc);
    assign push_keep  = push && !miss;

    always_comb begin
        meta_dir = 2'b00;
        if ((head_gh == res_taken_i) && (head_ph != res_taken_i)) begin
            meta_dir = 2'b01;
        end else if ((head_gh != res_taken_i) && (head_ph == res_taken_i)) begin
            meta_dir = 2'b10;
        end
    end

    always_comb begin
        state_d  = state_q;
        recov_d  = recov_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_keep) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        unique case (state_q)
            StRun: begin
                // A mispredict invalidates every younger entry, including this cycle's push.
                if (miss) begin
                    state_d  = StRecover;
                    recov_d  = RecovTop;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
            StRecover: begin
                if (recov_q == '0) begin
                    state_d = StRun;
                end else begin
                    recov_d = recov_q - Cw'(1);
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StRun;
            recov_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            recov_q  <= recov_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_keep) begin
            pc_mem_q[wr_ptr_q[Aw-1:0]]   <= pc_i;
            nex_mem_q[wr_ptr_q[Aw-1:0]]  <= nex_pc_i;
            gh_mem_q[wr_ptr_q[Aw-1:0]]   <= prediction_gh_i;
            ph_mem_q[wr_ptr_q[Aw-1:0]]   <= prediction_ph_i;
            pred_mem_q[wr_ptr_q[Aw-1:0]] <= prediction_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            upd_valid_q  <= 1'b0;
            upd_pc_q     <= '0;
            fix_result_q <= 1'b0;
            meta_dir_q   <= 2'b00;
            mispredict_q <= 1'b0;
            fix_pc_q     <= '0;
            miss_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            upd_valid_q  <= pop;
            mispredict_q <= miss;
            if (pop) begin
                upd_pc_q     <= head_pc;
                fix_result_q <= res_taken_i;
                meta_dir_q   <= meta_dir;
                fix_pc_q     <= miss ? correct_pc : 32'h0;
            end
            if (miss && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
            // Drops during RECOVER are expected back-pressure, not an overflow.
            if (pred_valid_i && !pred_ready_o && (state_q == StRun)) begin
                overflow_q <= 1'b1;
            end
            if (res_valid_i && (empty || (state_q == StRecover))) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign upd_valid_o  = upd_valid_q;
    assign upd_pc_o     = upd_pc_q;
    assign fix_result_o = fix_result_q;
    assign meta_dir_o   = meta_dir_q;
    assign mispredict_o = mispredict_q;
    assign fix_pc_o     = fix_pc_q;
    assign miss_cnt_o   = miss_cnt_q;
    assign overflow_o   = overflow_q;
    assign underflow_o  = underflow_q;

endmodule

// File: tb/tb_torneo_resolver.sv
// Directed bench for torneo_resolver: hand-computed expectations for issue, resolve,
// mispredict recovery, full/empty edges, PC wrap and asynchronous reset.
module tb_torneo_resolver;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        pred_valid_i = 1'b0;
    logic        pred_ready_o;
    logic [31:0] pc_i = '0;
    logic        prediction_gh_i = 1'b0;
    logic        prediction_ph_i = 1'b0;
    logic        prediction_i = 1'b0;
    logic [31:0] nex_pc_i = '0;
    logic        res_valid_i = 1'b0;
    logic        res_taken_i = 1'b0;
    logic [31:0] res_target_i = '0;
    logic        upd_valid_o;
    logic [31:0] upd_pc_o;
    logic        fix_result_o;
    logic [1:0]  meta_dir_o;
    logic        mispredict_o;
    logic [31:0] fix_pc_o;
    logic [15:0] miss_cnt_o;
    logic        overflow_o;
    logic        underflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    torneo_resolver #(
        .Depth    (8),
        .PcStep   (4),
        .RecovCyc (3)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pred_valid_i    (pred_valid_i),
        .pred_ready_o    (pred_ready_o),
        .pc_i            (pc_i),
        .prediction_gh_i (prediction_gh_i),
        .prediction_ph_i (prediction_ph_i),
        .prediction_i    (prediction_i),
        .nex_pc_i        (nex_pc_i),
        .res_valid_i     (res_valid_i),
        .res_taken_i     (res_taken_i),
        .res_target_i    (res_target_i),
        .upd_valid_o     (upd_valid_o),
        .upd_pc_o        (upd_pc_o),
        .fix_result_o    (fix_result_o),
        .meta_dir_o      (meta_dir_o),
        .mispredict_o    (mispredict_o),
        .fix_pc_o        (fix_pc_o),
        .miss_cnt_o      (miss_cnt_o),
        .overflow_o      (overflow_o),
        .underflow_o     (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] nex, input logic gh,
                        input logic ph, input logic pr);
        pred_valid_i    = 1'b1;
        pc_i            = pc;
        nex_pc_i        = nex;
        prediction_gh_i = gh;
        prediction_ph_i = ph;
        prediction_i    = pr;
        tick();
        pred_valid_i = 1'b0;
    endtask

    task automatic resolve(input logic taken, input logic [31:0] target);
        res_valid_i  = 1'b1;
        res_taken_i  = taken;
        res_target_i = target;
        tick();
        res_valid_i = 1'b0;
    endtask

    initial begin
        #12;
        rst_i = 1'b0;
        tick();

        // Reset state
        check_eq("rst_ready", 32'(pred_ready_o), 32'd1);
        check_eq("rst_upd_valid", 32'(upd_valid_o), 32'd0);
        check_eq("rst_miss_cnt", 32'(miss_cnt_o), 32'd0);
        check_eq("rst_flags", {30'd0, overflow_o, underflow_o}, 32'd0);

        // 1: correct not-taken prediction, gshare right -> meta toward gh
        push(32'h10, 32'h14, 1'b0, 1'b1, 1'b0);
        resolve(1'b0, 32'h0);
        check_eq("t1_upd_valid", 32'(upd_valid_o), 32'd1);
        check_eq("t1_upd_pc", upd_pc_o, 32'h10);
        check_eq("t1_fix_result", 32'(fix_result_o), 32'd0);
        check_eq("t1_meta_dir", 32'(meta_dir_o), 32'd1);
        check_eq("t1_mispredict", 32'(mispredict_o), 32'd0);
        tick();
        check_eq("t1_upd_pulse", 32'(upd_valid_o), 32'd0);

        // 2: taken to 0x80 but predicted fall-through -> redirect and recovery window
        push(32'h20, 32'h24, 1'b0, 1'b1, 1'b0);
        resolve(1'b1, 32'h80);
        check_eq("t2_mispredict", 32'(mispredict_o), 32'd1);
        check_eq("t2_fix_pc", fix_pc_o, 32'h80);
        check_eq("t2_meta_dir", 32'(meta_dir_o), 32'd2);
        check_eq("t2_miss_cnt", 32'(miss_cnt_o), 32'd1);
        check_eq("t2_ready_c1", 32'(pred_ready_o), 32'd0);
        tick();
        check_eq("t2_miss_pulse", 32'(mispredict_o), 32'd0);
        check_eq("t2_ready_c2", 32'(pred_ready_o), 32'd0);
        tick();
        check_eq("t2_ready_c3", 32'(pred_ready_o), 32'd0);
        tick();
        check_eq("t2_ready_back", 32'(pred_ready_o), 32'd1);

        // 3: fill the FIFO, then a refused 9th push flags overflow only
        for (int i = 0; i < 8; i++) begin
            push(32'h100 + 32'(i) * 32'd4, 32'h104 + 32'(i) * 32'd4, 1'b0, 1'b0, 1'b0);
        end
        check_eq("t3_full_ready", 32'(pred_ready_o), 32'd0);
        check_eq("t3_no_ovf_yet", 32'(overflow_o), 32'd0);
        push(32'hDEAD0, 32'hDEAD4, 1'b0, 1'b0, 1'b0);
        check_eq("t3_overflow", 32'(overflow_o), 32'd1);
        res_valid_i = 1'b1;
        res_taken_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq($sformatf("t3_pop%0d_pc", i), upd_pc_o, 32'h100 + 32'(i) * 32'd4);
            check_eq($sformatf("t3_pop%0d_miss", i), 32'(mispredict_o), 32'd0);
        end
        res_valid_i = 1'b0;
        check_eq("t3_no_underflow", 32'(underflow_o), 32'd0);
        tick();
        check_eq("t3_drained", 32'(upd_valid_o), 32'd0);

        // 4: mispredict with 3 entries behind it and a same-cycle push
        for (int i = 0; i < 4; i++) begin
            push(32'h200 + 32'(i) * 32'd4, 32'h204 + 32'(i) * 32'd4, 1'b0, 1'b0, 1'b0);
        end
        pred_valid_i = 1'b1;
        pc_i         = 32'h300;
        nex_pc_i     = 32'h304;
        resolve(1'b1, 32'h9990);
        pred_valid_i = 1'b0;
        check_eq("t4_mispredict", 32'(mispredict_o), 32'd1);
        check_eq("t4_fix_pc", fix_pc_o, 32'h9990);
        check_eq("t4_miss_cnt", 32'(miss_cnt_o), 32'd2);
        resolve(1'b0, 32'h0);
        check_eq("t4_recover_ignored", 32'(upd_valid_o), 32'd0);
        check_eq("t4_underflow", 32'(underflow_o), 32'd1);
        tick();
        tick();
        check_eq("t4_ready_back", 32'(pred_ready_o), 32'd1);
        push(32'h400, 32'h404, 1'b0, 1'b0, 1'b0);
        resolve(1'b0, 32'h0);
        check_eq("t4_flushed_head", upd_pc_o, 32'h400);

        // 5: fall-through wraps past 2^32
        push(32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 1'b0);
        resolve(1'b0, 32'h0);
        check_eq("t5_upd_valid", 32'(upd_valid_o), 32'd1);
        check_eq("t5_mispredict", 32'(mispredict_o), 32'd0);
        check_eq("t5_fix_pc", fix_pc_o, 32'h0);
        check_eq("t5_meta_hold", 32'(meta_dir_o), 32'd0);

        // 6: asynchronous reset while in RECOVER
        for (int i = 0; i < 3; i++) begin
            push(32'h500 + 32'(i) * 32'd4, 32'h504 + 32'(i) * 32'd4, 1'b0, 1'b0, 1'b0);
        end
        resolve(1'b1, 32'h7000);
        check_eq("t6_in_recover", 32'(pred_ready_o), 32'd0);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("t6_rst_upd", {31'd0, upd_valid_o}, 32'd0);
        check_eq("t6_rst_miss", {15'd0, mispredict_o, miss_cnt_o}, 32'd0);
        check_eq("t6_rst_fix_pc", fix_pc_o, 32'h0);
        check_eq("t6_rst_upd_pc", upd_pc_o, 32'h0);
        check_eq("t6_rst_flags", {30'd0, overflow_o, underflow_o}, 32'd0);
        check_eq("t6_rst_ready", 32'(pred_ready_o), 32'd1);
        #3;
        rst_i = 1'b0;
        tick();
        check_eq("t6_ready_after", 32'(pred_ready_o), 32'd1);
        resolve(1'b0, 32'h0);
        check_eq("t6_empty_no_upd", 32'(upd_valid_o), 32'd0);
        check_eq("t6_empty_underflow", 32'(underflow_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
